vga_scan_timing: RTL and testbench
==================================

// Module: vga_scan_timing
// PURPOSE
//  Raster scan generator and VGA output stage. Produces the pixel coordinates (px, py) and
//  the per-frame pulse consumed by the rasterizer. Takes back the rasterizer's 4-bit r/g/b for
//  that coordinate, blanks it outside the active area, and registers it to the VGA pins
//  together with hsync/vsync, all delay-aligned.
// PARAMETERS
//  CLK_DIV     4    clk cycles per pixel tick (100 MHz clk -> 25 MHz pixel); >=1
//  H_ACTIVE    640  visible pixels per line
//  H_FP        16   horizontal front porch, in pixels
//  H_SYNC      96   hsync width, in pixels
//  H_BP        48   horizontal back porch; H_TOTAL = sum of the four = 800
//  V_ACTIVE    480  visible lines
//  V_FP        10   vertical front porch, in lines
//  V_SYNC      2    vsync width, in lines
//  V_BP        33   vertical back porch; V_TOTAL = sum of the four = 525
//  PIPE_DEPTH  0    pixel ticks of renderer latency between px/py and r_in/g_in/b_in (0..7)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous, active-high reset
//  px         out  10  horizontal counter hcnt (0..H_TOTAL-1), combinational from counter reg
//  py         out  10  vertical counter vcnt (0..V_TOTAL-1), combinational from counter reg
//  frame      out  1   one-clk pulse at start of vertical blank
//  pix_tick   out  1   one-clk strobe, high on the cycle the counters advance
//  r_in, g_in, b_in  in  4 each  colour from the renderer for px/py of PIPE_DEPTH ticks ago
//  test_mode  in   1   select internal colour bars (used only with VGA_TEST_PATTERN_EN)
//  vga_r, vga_g, vga_b  out  4 each  registered pixel colour
//  vga_hs     out  1   hsync, active low, registered
//  vga_vs     out  1   vsync, active low, registered
//  vga_de     out  1   data enable (active video), registered
// BEHAVIOUR
//  - Reset (synchronous, active-high, clk domain only):
//    - divider, hcnt and vcnt go to 0; all delay-line stages go to inactive (hs=1, vs=1, de=0).
//    - vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_de=0, frame=0, pix_tick=0.
//    - Reset asserted mid-line restarts at (0,0) on the next cycle. No partial-state carry-over.
//  - Divider:
//    - counts 0..CLK_DIV-1.
//    - pix_tick=1 on the cycle the divider equals CLK_DIV-1.
//    - CLK_DIV=1: pix_tick constantly 1 after reset.
//  - Counters advance only on pix_tick:
//    - hcnt==H_TOTAL-1 -> hcnt=0 and vcnt increments.
//    - vcnt==V_TOTAL-1 at the same wrap -> vcnt=0.
//  - Raw timing from counter state S:
//    - de   = hcnt<H_ACTIVE && vcnt<V_ACTIVE
//    - hs_n = !(hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1])
//    - vs_n = !(vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1])
//  - Alignment: {de,hs_n,vs_n} pass through a PIPE_DEPTH-stage shift register clocked on pix_tick.
//  - Output register, on pix_tick:
//    - vga_hs/vs/de <= delayed timing.
//    - vga_rgb <= delayed de ? colour : 0.
//    - Pin latency = PIPE_DEPTH+1 ticks after the counter state.
//    - Outputs hold between ticks.
//  - frame: high exactly one clk, on the pix_tick where hcnt wraps to 0 and vcnt becomes V_ACTIVE.
//    Once per V_TOTAL*H_TOTAL ticks.
//  - r_in/g_in/b_in are sampled only on pix_tick and never in blanking. No handshake; free-running.
// CONFIGURATION
//  - `VGA_TEST_PATTERN_EN` defined:
//    - when test_mode=1, the colour source is 8 vertical bars of H_ACTIVE/8 px, selected by the
//      delayed hcnt[9:0]/80.
//    - bar order: white F/F/F, yellow F/F/0, cyan 0/F/F, green 0/F/0, magenta F/0/F, red F/0/0,
//      blue 0/0/F, black 0/0/0.
//    - test_mode=0 uses r_in/g_in/b_in.
//  - Macro undefined: port test_mode is present but ignored; no bar logic is synthesised.
// STRUCTURE
//  - graphics_type.sv:
//    - add typedef vga_timing_t {logic de, hs_n, vs_n;}.
//    - add the 640x480@60 default constants.
//    - reuse color_t for the colour path.
//  - Sub-module vga_sync_delay: parameterised PIPE_DEPTH shift register of vga_timing_t + hcnt.
//    - enable = pix_tick; PIPE_DEPTH=0 is a wire.
// TESTING
//  1. Reset, run 2 lines, CLK_DIV=4 -> pix_tick every 4th clk.
//     - vga_hs falls 657 ticks after counter (0,0) and stays low 96 ticks.
//     - hs period 800 ticks.
//  2. Run a full frame -> vga_vs low exactly during lines 490-491 (+1 tick latency).
//     - frame pulses once at (0,480); next pulse 420000 ticks later.
//  3. Drive r_in=F,g_in=0,b_in=0 constantly -> vga_r=F only while vga_de=1.
//     - vga_r=0 at hcnt 640..799 and lines 480..524.
//  4. PIPE_DEPTH=2, r_in = hcnt[3:0] delayed 2 ticks by the bench ->
//     - vga_r equals the px 3 ticks earlier.
//     - first de-high pixel carries px=0 value.
//  5. Assert rst for 1 clk at hcnt=300,vcnt=100 -> outputs at reset values next clk; px,py=0.
//     - hs period resumes as 800 from there.
//  6. With VGA_TEST_PATTERN_EN, test_mode=1 -> pixels 0..79 white, 80..159 yellow,
//     560..639 black, on every active line.

Source files
------------

// File: rtl/vga_scan_timing_pkg.sv
// Shared types and 640x480@60 timing defaults for the VGA scan generator.
package vga_scan_timing_pkg;

  typedef struct packed {
    logic de;
    logic hs_n;
    logic vs_n;
  } vga_timing_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } color_t;

  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam vga_timing_t TIMING_IDLE = '{de: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  function automatic color_t bar_color(input logic [2:0] idx);
    color_t c;
    case (idx)
      3'd0:    c = '{r: 4'hF, g: 4'hF, b: 4'hF};
      3'd1:    c = '{r: 4'hF, g: 4'hF, b: 4'h0};
      3'd2:    c = '{r: 4'h0, g: 4'hF, b: 4'hF};
      3'd3:    c = '{r: 4'h0, g: 4'hF, b: 4'h0};
      3'd4:    c = '{r: 4'hF, g: 4'h0, b: 4'hF};
      3'd5:    c = '{r: 4'hF, g: 4'h0, b: 4'h0};
      3'd6:    c = '{r: 4'h0, g: 4'h0, b: 4'hF};
      default: c = '{r: 4'h0, g: 4'h0, b: 4'h0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_scan_timing_sync_delay.sv
// Delays raw sync/blank timing and hcnt by PIPE_DEPTH pixel ticks so they line
// up with the renderer's colour latency. PIPE_DEPTH=0 is a plain wire.
module vga_sync_delay
  import vga_scan_timing_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] timing_in,
  input  logic [9:0] hcnt_in,
  output logic [2:0] timing_out,
  output logic [9:0] hcnt_out
);

  if (PIPE_DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, en};
    assign timing_out = timing_in;
    assign hcnt_out   = hcnt_in;
  end else begin : g_pipe
    vga_timing_t tim_q  [PIPE_DEPTH];
    logic [9:0]  hcnt_q [PIPE_DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
          tim_q[i]  <= TIMING_IDLE;
          hcnt_q[i] <= '0;
        end
      end else if (en) begin
        tim_q[0]  <= timing_in;
        hcnt_q[0] <= hcnt_in;
        for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
          tim_q[i]  <= tim_q[i-1];
          hcnt_q[i] <= hcnt_q[i-1];
        end
      end
    end

    assign timing_out = tim_q[PIPE_DEPTH-1];
    assign hcnt_out   = hcnt_q[PIPE_DEPTH-1];
  end

endmodule

// File: rtl/vga_scan_timing.sv
// Raster scan counters plus registered VGA output stage with delay-aligned sync.
// Optional colour-bar source: define VGA_TEST_PATTERN_EN.
module vga_scan_timing
  import vga_scan_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned PIPE_DEPTH = 0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] px,
  output logic [9:0] py,
  output logic       frame,
  output logic       pix_tick,
  input  logic [3:0] r_in,
  input  logic [3:0] g_in,
  input  logic [3:0] b_in,
  input  logic       test_mode,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_de
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_M1 = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div;
  logic [9:0]       hcnt;
  logic [9:0]       vcnt;
  logic             h_wrap;
  logic             v_wrap;
  vga_timing_t      raw;
  vga_timing_t      dly;
  logic [2:0]       dly_bits;
  logic [9:0]       hcnt_d;
  color_t           src;

  assign pix_tick = (div == DIV_LAST);
  assign h_wrap   = (hcnt == H_LAST);
  assign v_wrap   = (vcnt == V_LAST);
  assign frame    = pix_tick && h_wrap && (vcnt == V_ACT_M1);
  assign px       = hcnt;
  assign py       = vcnt;

  always_ff @(posedge clk) begin
    if (rst || pix_tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_tick) begin
      if (h_wrap) begin
        hcnt <= '0;
        vcnt <= v_wrap ? 10'd0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  always_comb begin
    raw      = TIMING_IDLE;
    raw.de   = (hcnt < H_ACT) && (vcnt < V_ACT);
    raw.hs_n = !((hcnt >= HS_FIRST) && (hcnt <= HS_LAST));
    raw.vs_n = !((vcnt >= VS_FIRST) && (vcnt <= VS_LAST));
  end

  vga_sync_delay #(
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_sync_delay (
    .clk        (clk),
    .rst        (rst),
    .en         (pix_tick),
    .timing_in  (raw),
    .hcnt_in    (hcnt),
    .timing_out (dly_bits),
    .hcnt_out   (hcnt_d)
  );

  assign dly = dly_bits;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

  // Bar index only matters while the delayed pixel is active (hcnt_d < H_ACTIVE).
  always_comb begin
    src = '{r: r_in, g: g_in, b: b_in};
    if (test_mode) begin
      src = bar_color(3'(hcnt_d / BAR_W));
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{test_mode, hcnt_d};

  always_comb begin
    src = '{r: r_in, g: g_in, b: b_in};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_de <= 1'b0;
    end else if (pix_tick) begin
      vga_hs <= dly.hs_n;
      vga_vs <= dly.vs_n;
      vga_de <= dly.de;
      if (dly.de) begin
        vga_r <= src.r;
        vga_g <= src.g;
        vga_b <= src.b;
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_timing.sv
// Scoreboard bench for vga_scan_timing on a shrunken raster; a second instance
// with CLK_DIV=1 and no pipeline exercises the single-cycle tick path.
module tb_vga_scan_timing;

  localparam int CLK_DIV = 4;
  localparam int PD  = 2;
  localparam int HA  = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA  = 6,  VFP = 1, VSY = 2, VBP = 1;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam int FR  = HT * VT * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] px, py;
  logic       frame, pix_tick;
  logic [3:0] r_in = 4'h0, g_in = 4'h0, b_in = 4'h0;
  logic       test_mode = 1'b0;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_de;

  logic [9:0] px_b, py_b;
  logic       frame_b, pix_tick_b;
  logic [3:0] r_in_b = 4'h0;
  logic [3:0] vga_r_b, vga_g_b, vga_b_b;
  logic       vga_hs_b, vga_vs_b, vga_de_b;

  vga_scan_timing #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .PIPE_DEPTH(PD)
  ) dut (
    .clk(clk), .rst(rst), .px(px), .py(py), .frame(frame), .pix_tick(pix_tick),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .test_mode(test_mode),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de)
  );

  vga_scan_timing #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .PIPE_DEPTH(0)
  ) dut_b (
    .clk(clk), .rst(rst), .px(px_b), .py(py_b), .frame(frame_b), .pix_tick(pix_tick_b),
    .r_in(r_in_b), .g_in(4'h5), .b_in(4'hA), .test_mode(1'b0),
    .vga_r(vga_r_b), .vga_g(vga_g_b), .vga_b(vga_b_b),
    .vga_hs(vga_hs_b), .vga_vs(vga_vs_b), .vga_de(vga_de_b)
  );

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } pins_t;

  pins_t       exp_q[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, k = 0, mode = 0;
  bit          tick_exp = 0;
  logic [11:0] col_ring [8];
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                            12'hF0F, 12'hF00, 12'h00F, 12'h000};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Raster geometry of the n-th counter state after reset.
  function automatic int hpos(input int n); return n % HT; endfunction
  function automatic int vpos(input int n); return (n / HT) % VT; endfunction
  function automatic bit in_de(input int n); return hpos(n) < HA && vpos(n) < VA; endfunction
  function automatic bit hs_low(input int n);
    return hpos(n) >= HA + HFP && hpos(n) < HA + HFP + HSY;
  endfunction
  function automatic bit vs_low(input int n);
    return vpos(n) >= VA + VFP && vpos(n) < VA + VFP + VSY;
  endfunction

  // One clock: account for the edge just taken, check counters, drive inputs.
  task automatic cycle();
    int j;
    pins_t e;
    logic [11:0] src;
    @(posedge clk);
    #1;
    if (rst) begin
      cyc = 0;
      k = 0;
      exp_q.delete();
      check("rst_vga_rgb", int'({vga_r, vga_g, vga_b}), 0);
      check("rst_vga_hs", int'(vga_hs), 1);
      check("rst_vga_vs", int'(vga_vs), 1);
      check("rst_vga_de", int'(vga_de), 0);
    end else begin
      if (tick_exp) k++;
      cyc++;
    end
    tick_exp = (cyc % CLK_DIV) == CLK_DIV - 1;
    check("px", int'(px), hpos(k));
    check("py", int'(py), vpos(k));
    check("pix_tick", int'(pix_tick), int'(tick_exp));
    check("frame", int'(frame), int'(tick_exp && hpos(k) == HT - 1 && vpos(k) == VA - 1));
    if (cyc % CLK_DIV == 0) begin
      case (mode)
        1:       col_ring[k % 8] = 12'hF00;
        2:       col_ring[k % 8] = {4'(hpos(k)), ~4'(hpos(k)), 4'(hpos(k) ^ vpos(k))};
        default: col_ring[k % 8] = 12'($urandom);
      endcase
    end
    {r_in, g_in, b_in} = col_ring[(k + 8 - PD) % 8];
`ifdef VGA_TEST_PATTERN_EN
    test_mode = (mode == 3);
`else
    test_mode = (mode == 3) ? 1'b1 : 1'($urandom);
`endif
    if (tick_exp) begin
      j = k - PD;
      e = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      if (j >= 0) begin
        src = col_ring[j % 8];
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode && in_de(j)) src = bars[hpos(j) / (HA / 8)];
`endif
        e.de  = in_de(j);
        e.hs  = !hs_low(j);
        e.vs  = !vs_low(j);
        e.rgb = e.de ? src : 12'h000;
      end
      exp_q.push_back(e);
    end
  endtask

  // Monitor: after every accepted tick the pins must match the queued expectation.
  bit pend = 0;
  always @(negedge clk) begin
    pins_t e;
    if (pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pins_queue: output update with no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("vga_de", int'(vga_de), int'(e.de));
        check("vga_hs", int'(vga_hs), int'(e.hs));
        check("vga_vs", int'(vga_vs), int'(e.vs));
        check("vga_rgb", int'({vga_r, vga_g, vga_b}), int'(e.rgb));
      end
    end
    pend = pix_tick && !rst;
  end

  // Interval measurements in pixel ticks since the last reset.
  int   tno = 0, hs_fall = -1, vs_fall = -1, fr_last = -1;
  logic hs_p = 1'b1, vs_p = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      tno = 0; hs_fall = -1; vs_fall = -1; fr_last = -1;
      hs_p = 1'b1; vs_p = 1'b1;
    end else begin
      if (hs_p && !vga_hs) begin
        if (hs_fall < 0) check("hs_first_fall", tno, HA + HFP + PD + 1);
        else check("hs_period", tno - hs_fall, HT);
        hs_fall = tno;
      end
      if (!hs_p && vga_hs && hs_fall >= 0) check("hs_width", tno - hs_fall, HSY);
      if (vs_p && !vga_vs) begin
        if (vs_fall < 0) check("vs_first_fall", tno, (VA + VFP) * HT + PD + 1);
        else check("vs_period", tno - vs_fall, HT * VT);
        vs_fall = tno;
      end
      if (!vs_p && vga_vs && vs_fall >= 0) check("vs_width", tno - vs_fall, VSY * HT);
      if (frame) begin
        if (fr_last < 0) check("frame_first", tno, VA * HT - 1);
        else check("frame_period", tno - fr_last, HT * VT);
        fr_last = tno;
      end
      if (!vga_de) check("blank_rgb", int'({vga_r, vga_g, vga_b}), 0);
      hs_p = vga_hs;
      vs_p = vga_vs;
      if (pix_tick) tno++;
    end
  end

  // Second instance: tick every clk, colour is the low nibble of px with no latency.
  logic rst_e = 1'b0;
  int   kb = -1, jb;
  always @(posedge clk) rst_e <= rst;
  always @(negedge clk) begin
    if (rst_e) kb = 0;
    else if (kb >= 0) kb++;
    if (kb >= 0) begin
      check("b_px", int'(px_b), hpos(kb));
      check("b_py", int'(py_b), vpos(kb));
      check("b_pix_tick", int'(pix_tick_b), 1);
      if (kb == 0) begin
        check("b_rst_pins", int'({vga_hs_b, vga_vs_b, vga_de_b, vga_r_b}), 'h60);
      end else begin
        jb = kb - 1;
        check("b_de", int'(vga_de_b), int'(in_de(jb)));
        check("b_hs", int'(vga_hs_b), int'(!hs_low(jb)));
        check("b_vs", int'(vga_vs_b), int'(!vs_low(jb)));
        check("b_r", int'(vga_r_b), in_de(jb) ? hpos(jb) % 16 : 0);
      end
      r_in_b = 4'(hpos(kb));
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 8; i++) col_ring[i] = 12'h000;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    mode = 0; repeat (2 * FR) cycle();
    mode = 1; repeat (FR) cycle();
    mode = 2; repeat (FR) cycle();
    mode = 0;
    n = 0;
    while (!(hpos(k) == 10 && vpos(k) == 3 && (cyc % CLK_DIV) == 1) && n < FR) begin
      cycle();
      n++;
    end
    if (n >= FR) begin
      checks++;
      errors++;
      $display("FAIL mid_reset_position: not reached within %0d cycles", FR);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    mode = 3; repeat (2 * FR) cycle();
    mode = 0; repeat (FR / 2) cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
